l2_mem_bridge: RTL and testbench

Downstream neighbour of the 4-way 128-bit L2 cache. Accepts the cache's single-beat 128-bit line read/write requests (waitrequest/readdata_valid handshake) and converts each into four 32-bit word transactions on a 32-bit external memory port. Read responses are reassembled into one 128-bit line and returned with a single valid pulse. Keeps per-line traffic counters.

---
 rtl/l2_mem_bridge.sv | 176 +++++++++++++++++
 tb/tb_l2_mem_bridge.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_bridge.sv
// rtl/l2_mem_bridge.sv - splits 128-bit cache line requests into four 32-bit memory word transactions
module l2_mem_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_s_addr,
    input  logic [3:0]   i_s_byte_en,
    input  logic [127:0] i_s_writedata,
    input  logic         i_s_read,
    input  logic         i_s_write,
    output logic [127:0] o_s_readdata,
    output logic         o_s_readdata_valid,
    output logic         o_s_waitrequest,
    output logic [31:0]  o_m_addr,
    output logic [3:0]   o_m_byteenable,
    output logic [31:0]  o_m_writedata,
    output logic         o_m_read,
    output logic         o_m_write,
    input  logic [31:0]  i_m_readdata,
    input  logic         i_m_readdata_valid,
    input  logic         i_m_waitrequest,
    output logic [31:0]  cnt_rd_line,
    output logic [31:0]  cnt_wr_line
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [31:0]  base_q, base_d;
    logic [3:0]   byte_en_q, byte_en_d;
    logic [127:0] wdata_q, wdata_d;
    logic [2:0]   cmd_cnt_q, cmd_cnt_d;
    logic [2:0]   rsp_cnt_q, rsp_cnt_d;
    logic [95:0]  asm_q, asm_d;
    logic [127:0] rdata_q, rdata_d;
    logic         rvalid_q, rvalid_d;
    logic [31:0]  cnt_rd_q, cnt_rd_d;
    logic [31:0]  cnt_wr_q, cnt_wr_d;

    logic [2:0]   outstanding;
    logic [1:0]   word_idx;
    logic         rd_issue;
    logic         wr_issue;

    // Command strobes derive only from registered state; reset gates them so nothing leaks out while held
    always_comb begin
        outstanding = cmd_cnt_q - rsp_cnt_q;
        word_idx    = cmd_cnt_q[1:0];
        rd_issue    = rst && (state_q == ST_RD) && (cmd_cnt_q < 3'd4)
                      && ({29'd0, outstanding} < MAX_OUTSTANDING);
        wr_issue    = rst && (state_q == ST_WR) && (cmd_cnt_q < 3'd4);
    end

    // Memory-side beat outputs; idle drives zeros so the port is quiet between lines
    always_comb begin
        o_m_read       = rd_issue;
        o_m_write      = wr_issue;
        o_m_addr       = 32'd0;
        o_m_byteenable = 4'h0;
        o_m_writedata  = 32'd0;
        if (state_q == ST_RD) begin
            o_m_addr       = base_q + {27'd0, cmd_cnt_q, 2'b00};
            o_m_byteenable = 4'hF;
        end else if (state_q == ST_WR) begin
            o_m_addr       = base_q + {27'd0, cmd_cnt_q, 2'b00};
            o_m_byteenable = byte_en_q[word_idx] ? 4'hF : 4'h0;
            o_m_writedata  = wdata_q[{word_idx, 5'd0} +: 32];
        end
    end

    // Cache-side outputs; the line register only moves when a whole line has been assembled
    always_comb begin
        o_s_readdata       = rdata_q;
        o_s_readdata_valid = rvalid_q;
        o_s_waitrequest    = !rst || (state_q != ST_IDLE);
        cnt_rd_line        = cnt_rd_q;
        cnt_wr_line        = cnt_wr_q;
    end

    // Next-state logic: request capture, beat sequencing and response reassembly
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        byte_en_d = byte_en_q;
        wdata_d   = wdata_q;
        cmd_cnt_d = cmd_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        asm_d     = asm_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        cnt_rd_d  = cnt_rd_q;
        cnt_wr_d  = cnt_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_s_read || i_s_write) begin
                    base_d    = i_s_addr & 32'hFFFF_FFF0;
                    byte_en_d = i_s_byte_en;
                    wdata_d   = i_s_writedata;
                    cmd_cnt_d = 3'd0;
                    rsp_cnt_d = 3'd0;
                    // read wins when both are raised
                    state_d   = i_s_read ? ST_RD : ST_WR;
                end
            end
            ST_RD: begin
                if (rd_issue && !i_m_waitrequest) begin
                    cmd_cnt_d = cmd_cnt_q + 3'd1;
                end
                if (i_m_readdata_valid) begin
                    if (rsp_cnt_q == 3'd3) begin
                        rdata_d   = {i_m_readdata, asm_q};
                        rvalid_d  = 1'b1;
                        cnt_rd_d  = cnt_rd_q + 32'd1;
                        cmd_cnt_d = 3'd0;
                        rsp_cnt_d = 3'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        case (rsp_cnt_q[1:0])
                            2'd0:    asm_d[31:0]  = i_m_readdata;
                            2'd1:    asm_d[63:32] = i_m_readdata;
                            default: asm_d[95:64] = i_m_readdata;
                        endcase
                        rsp_cnt_d = rsp_cnt_q + 3'd1;
                    end
                end
            end
            ST_WR: begin
                if (!i_m_waitrequest) begin
                    if (cmd_cnt_q == 3'd3) begin
                        cmd_cnt_d = 3'd0;
                        cnt_wr_d  = cnt_wr_q + 32'd1;
                        state_d   = ST_IDLE;
                    end else begin
                        cmd_cnt_d = cmd_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any line in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            base_q    <= 32'd0;
            byte_en_q <= 4'h0;
            wdata_q   <= 128'd0;
            cmd_cnt_q <= 3'd0;
            rsp_cnt_q <= 3'd0;
            asm_q     <= 96'd0;
            rdata_q   <= 128'd0;
            rvalid_q  <= 1'b0;
            cnt_rd_q  <= 32'd0;
            cnt_wr_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            byte_en_q <= byte_en_d;
            wdata_q   <= wdata_d;
            cmd_cnt_q <= cmd_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            asm_q     <= asm_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            cnt_rd_q  <= cnt_rd_d;
            cnt_wr_q  <= cnt_wr_d;
        end
    end

endmodule

// File: tb/tb_l2_mem_bridge.sv
// tb/tb_l2_mem_bridge.sv - scoreboard bench for l2_mem_bridge (MAX_OUTSTANDING 4 and 1 instances)
module tb_l2_mem_bridge;

    typedef struct {
        int          id;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        int           id;
        logic [127:0] line;
    } line_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst     [2];
    logic [31:0]  s_addr  [2];
    logic [3:0]   s_be    [2];
    logic [127:0] s_wdata [2];
    logic         s_read  [2];
    logic         s_write [2];
    logic [127:0] s_rdata [2];
    logic         s_rvalid[2];
    logic         s_wait  [2];
    logic [31:0]  m_addr  [2];
    logic [3:0]   m_be    [2];
    logic [31:0]  m_wdata [2];
    logic         m_read  [2];
    logic         m_write [2];
    logic [31:0]  m_rdata [2];
    logic         m_rvalid[2];
    logic         m_wait  [2];
    logic [31:0]  cnt_rd  [2];
    logic [31:0]  cnt_wr  [2];

    int          n_pass  = 0;
    int          n_total = 0;
    cmd_t        exp_cmd_q[$];
    line_t       exp_line_q[$];
    int          acc_cyc[$];
    int          valid_cyc = -1;
    int          rsp_seen = 0;
    int          lat[2];
    logic [31:0] stall_addr = 32'h0000_0001;
    int          stall_cycles = 0;
    logic [31:0] mem [logic [31:0]];

    task automatic chk_eq(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] rdword(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_cmds(input int id, input bit wr, input logic [31:0] base,
                            input logic [3:0] be, input logic [127:0] data);
        for (int k = 0; k < 4; k++) begin
            exp_cmd_q.push_back('{id: id, wr: wr, addr: base + 32'(4 * k),
                                  be: (wr && !be[k]) ? 4'h0 : 4'hF,
                                  data: wr ? data[32 * k +: 32] : 32'h0});
        end
    endtask

    task automatic accept(input int g);
        int n = 0;
        while (s_wait[g] === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk_eq("accept_bound", 160'(n < 100), 160'(1));
        tick();
        s_read[g]  = 1'b0;
        s_write[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while (s_wait[g] !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk_eq("idle_bound", 160'(n < 200), 160'(1));
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned MAXO = (g == 0) ? 4 : 1;
        rsp_t        rq[$];
        logic        stalled = 1'b0;
        logic [69:0] held = '0;
        int          stalls_done = 0;

        l2_mem_bridge #(.MAX_OUTSTANDING(MAXO)) u_dut (
            .clk                (clk),
            .rst                (rst[g]),
            .i_s_addr           (s_addr[g]),
            .i_s_byte_en        (s_be[g]),
            .i_s_writedata      (s_wdata[g]),
            .i_s_read           (s_read[g]),
            .i_s_write          (s_write[g]),
            .o_s_readdata       (s_rdata[g]),
            .o_s_readdata_valid (s_rvalid[g]),
            .o_s_waitrequest    (s_wait[g]),
            .o_m_addr           (m_addr[g]),
            .o_m_byteenable     (m_be[g]),
            .o_m_writedata      (m_wdata[g]),
            .o_m_read           (m_read[g]),
            .o_m_write          (m_write[g]),
            .i_m_readdata       (m_rdata[g]),
            .i_m_readdata_valid (m_rvalid[g]),
            .i_m_waitrequest    (m_wait[g]),
            .cnt_rd_line        (cnt_rd[g]),
            .cnt_wr_line        (cnt_wr[g])
        );

        // Memory model: in-order responses after lat cycles, address-targeted stalls, command scoreboard
        always @(negedge clk) begin
            logic [69:0] cur;
            cmd_t        e;
            cur = {m_read[g], m_write[g], m_addr[g], m_be[g], m_wdata[g]};
            if (m_read[g] === 1'b1)
                chk_eq("outstanding_limit", 160'(rq.size() < int'(MAXO)), 160'(1));
            m_rvalid[g] = 1'b0;
            m_rdata[g]  = 32'h0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                m_rvalid[g] = 1'b1;
                m_rdata[g]  = rq[0].data;
                void'(rq.pop_front());
                rsp_seen++;
            end
            if (stalled) chk_eq("stall_hold", 160'(cur), 160'(held));
            m_wait[g] = 1'b0;
            if ((m_read[g] || m_write[g]) && m_addr[g] == stall_addr && stalls_done < stall_cycles) begin
                m_wait[g] = 1'b1;
                stalls_done++;
            end
            stalled = m_wait[g];
            held    = cur;
            if ((m_read[g] === 1'b1 || m_write[g] === 1'b1) && !m_wait[g]) begin
                acc_cyc.push_back(cyc);
                if (exp_cmd_q.size() == 0) begin
                    chk_eq("unexpected_cmd", 160'({m_read[g], m_write[g]}), 160'(0));
                end else begin
                    e = exp_cmd_q.pop_front();
                    chk_eq("cmd",
                           160'({8'(g), m_read[g], m_write[g], m_addr[g], m_be[g], m_write[g] ? m_wdata[g] : 32'h0}),
                           160'({8'(e.id), !e.wr, e.wr, e.addr, e.be, e.data}));
                end
                if (m_write[g]) begin
                    chk_eq("busy_during_write", 160'(s_wait[g]), 160'(1));
                    if (m_be[g] == 4'hF) mem[m_addr[g]] = m_wdata[g];
                end else begin
                    rq.push_back('{data: rdword(m_addr[g]), due: cyc + lat[g]});
                end
            end
        end

        // Line monitor: every valid pulse must match the next expected line for this instance
        always @(negedge clk) begin
            line_t e;
            if (s_rvalid[g] === 1'b1) begin
                valid_cyc = cyc;
                if (exp_line_q.size() == 0) begin
                    chk_eq("spurious_line_valid", 160'(s_rvalid[g]), 160'(0));
                end else begin
                    e = exp_line_q.pop_front();
                    chk_eq("line", 160'({8'(g), s_rdata[g]}), 160'({8'(e.id), e.line}));
                end
            end
        end
    end

    initial begin
        int a;
        int tgt;
        int n;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b0; s_read[g] = 1'b0; s_write[g] = 1'b0;
            s_addr[g] = 32'h0; s_be[g] = 4'h0; s_wdata[g] = 128'h0; lat[g] = 1;
        end
        mem[32'h0000_1230] = 32'h11; mem[32'h0000_1234] = 32'h22;
        mem[32'h0000_1238] = 32'h33; mem[32'h0000_123C] = 32'h44;

        // Reset held with a read already requested
        s_read[0] = 1'b1; s_addr[0] = 32'h0000_1238;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("rst_waitreq", 160'(s_wait[0]), 160'(1));
            chk_eq("rst_cmd", 160'({m_read[0], m_write[0], m_addr[0], m_be[0], m_wdata[0]}), 160'(0));
            chk_eq("rst_line", 160'({s_rvalid[0], s_rdata[0]}), 160'(0));
            chk_eq("rst_cnt", 160'({cnt_rd[0], cnt_wr[0]}), 160'(0));
        end
        exp_cmds(0, 1'b0, 32'h0000_1230, 4'hF, 128'h0);
        exp_line_q.push_back('{id: 0, line: 128'h00000044_00000033_00000022_00000011});
        acc_cyc.delete();
        rst[0] = 1'b1; rst[1] = 1'b1;
        #1;
        chk_eq("post_rst_waitreq", 160'(s_wait[0]), 160'(0));
        accept(0);
        a = cyc;
        wait_idle(0);
        tick(); tick();
        chk_eq("rd_beats", 160'(acc_cyc.size()), 160'(4));
        if (acc_cyc.size() == 4) begin
            chk_eq("rd_first_beat_cyc", 160'(acc_cyc[0]), 160'(a));
            chk_eq("rd_last_beat_cyc", 160'(acc_cyc[3]), 160'(a + 3));
        end
        chk_eq("rd_valid_cyc", 160'(valid_cyc), 160'(a + 5));
        chk_eq("cnt_rd_1", 160'(cnt_rd[0]), 160'(1));

        // Partial-enable write with a two-cycle stall on beat 1
        stall_addr = 32'h0000_2004; stall_cycles = 2;
        exp_cmds(0, 1'b1, 32'h0000_2000, 4'b0101, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
        s_write[0] = 1'b1; s_addr[0] = 32'h0000_2000; s_be[0] = 4'b0101;
        s_wdata[0] = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
        accept(0);
        wait_idle(0);
        chk_eq("cnt_wr_1", 160'(cnt_wr[0]), 160'(1));
        chk_eq("cnt_rd_after_wr", 160'(cnt_rd[0]), 160'(1));

        // Write-back immediately followed by a fetch of the same line
        exp_cmds(0, 1'b1, 32'h0000_3000, 4'hF, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);
        s_write[0] = 1'b1; s_addr[0] = 32'h0000_3004; s_be[0] = 4'hF;
        s_wdata[0] = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
        accept(0);
        exp_cmds(0, 1'b0, 32'h0000_3000, 4'hF, 128'h0);
        exp_line_q.push_back('{id: 0, line: 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000});
        s_read[0] = 1'b1; s_addr[0] = 32'h0000_3000;
        accept(0);
        wait_idle(0);
        tick(); tick();
        chk_eq("cnt_wr_2", 160'(cnt_wr[0]), 160'(2));
        chk_eq("cnt_rd_2", 160'(cnt_rd[0]), 160'(2));

        // Reset after two responses; the stragglers must be ignored
        lat[0] = 3;
        exp_cmds(0, 1'b0, 32'h0000_4000, 4'hF, 128'h0);
        tgt = rsp_seen + 2;
        s_read[0] = 1'b1; s_addr[0] = 32'h0000_4000;
        accept(0);
        n = 0;
        while (rsp_seen < tgt && n < 50) begin
            tick();
            n++;
        end
        chk_eq("stale_wait_bound", 160'(n < 50), 160'(1));
        rst[0] = 1'b0;
        tick();
        rst[0] = 1'b1;
        repeat (4) tick();
        chk_eq("abandon_cnt", 160'({cnt_rd[0], cnt_wr[0]}), 160'(0));
        chk_eq("abandon_line", 160'(s_rdata[0]), 160'(0));
        chk_eq("abandon_idle", 160'(s_wait[0]), 160'(0));
        lat[0] = 1;
        exp_cmds(0, 1'b0, 32'hFFFF_FFF0, 4'hF, 128'h0);
        exp_line_q.push_back('{id: 0, line: 128'h00000003_00000007_0000000B_0000000F});
        s_read[0] = 1'b1; s_addr[0] = 32'hFFFF_FFF0;
        accept(0);
        wait_idle(0);
        tick(); tick();
        chk_eq("cnt_rd_after_abandon", 160'(cnt_rd[0]), 160'(1));

        // Single-outstanding instance against a 3-cycle memory
        lat[1] = 3;
        exp_cmds(1, 1'b0, 32'h0000_5000, 4'hF, 128'h0);
        exp_line_q.push_back('{id: 1, line: 128'hFFFFAFF3_FFFFAFF7_FFFFAFFB_FFFFAFFF});
        s_read[1] = 1'b1; s_addr[1] = 32'h0000_500C;
        accept(1);
        wait_idle(1);
        tick(); tick();
        chk_eq("cnt_rd_max1", 160'(cnt_rd[1]), 160'(1));

        repeat (5) tick();
        chk_eq("cmd_queue_drained", 160'(exp_cmd_q.size()), 160'(0));
        chk_eq("line_queue_drained", 160'(exp_line_q.size()), 160'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
